// File: rtl/fp_div_seq_pkg.sv
// fp_div_seq_pkg: binary32 divider constants, flag indices, FSM states and unpacked-operand type
package fp_div_seq_pkg;
  localparam int EXP = 8;
  localparam int FRAC = 23;
  localparam int BIAS = 127;
  localparam int ITERS = FRAC + 3;
  localparam logic [31:0] QNAN_CANON = 32'h7FC00000;
  localparam int F_INVALID = 4;
  localparam int F_DIVIDE_BY_ZERO = 3;
  localparam int F_OVERFLOW = 2;
  localparam int F_UNDERFLOW = 1;
  localparam int F_INEXACT = 0;
  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [9:0] exp;
    logic [FRAC:0] mant;
    logic zero;
    logic inf;
    logic nan;
  } fp_unpacked_t;
  function automatic logic [4:0] lzc24(input logic [FRAC:0] m);
    lzc24 = 5'd0;
    for (int i = 0; i <= FRAC; i++) if (m[i]) lzc24 = 5'(FRAC - i);
  endfunction
endpackage

// File: rtl/fp_div_seq_unpack.sv
// fp_div_seq_unpack: classify a binary32 operand and normalize subnormals to a hidden-one mantissa
module fp_div_seq_unpack
  import fp_div_seq_pkg::*;
(
  input  logic [31:0]  bits,
  output fp_unpacked_t u
);
  logic [EXP-1:0] ef;
  logic [FRAC-1:0] ff;
  logic [4:0] lz;
  always_comb begin
    ef = bits[30:23];
    ff = bits[22:0];
    lz = lzc24({1'b0, ff});
    u.sign = bits[31];
    u.zero = ef == '0 && ff == '0;
    u.inf = &ef && ff == '0;
    u.nan = &ef && ff != '0;
    // subnormal: value is 0.f * 2^(1-bias), so shifting left by lz lowers the exponent by lz
    u.exp = ef != '0 ? 10'(ef) : 10'd1 - 10'(lz);
    u.mant = ef != '0 ? {1'b1, ff} : {1'b0, ff} << lz;
  end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle binary32 divider, radix-2 restoring recurrence with round-to-nearest-even
module fp_div_seq
  import fp_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_bits,
  input  logic [31:0] b_bits,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_bits,
  output logic [4:0]  except_flags,
  output logic        out_valid,
  input  logic        out_ready
);
  fp_unpacked_t ua, ub;
  state_t state;
  logic [31:0] a_q, b_q, spec_bits, rnd_bits;
  logic [24:0] r, m_r;
  logic [23:0] rem;
  logic [25:0] q;
  logic [9:0] e, e_r;
  logic [4:0] cnt, sf, rf;
  logic sign, nv, dz, inf_res, special, lt, ge, g, rb, st, inc, of, uf;

  fp_div_seq_unpack u_a (.bits(a_q), .u(ua));
  fp_div_seq_unpack u_b (.bits(b_q), .u(ub));

  assign in_ready = state == IDLE && !rst;

  always_comb begin
    sign = ua.sign ^ ub.sign;
    nv = ua.nan | ub.nan | (ua.zero & ub.zero) | (ua.inf & ub.inf);
    special = ua.nan | ub.nan | ua.zero | ub.zero | ua.inf | ub.inf;
    dz = !nv & ub.zero & !ua.inf;
    inf_res = ua.inf | ub.zero;
    spec_bits = nv ? QNAN_CANON : {sign, {EXP{inf_res}}, {FRAC{1'b0}}};
    sf = '0;
    sf[F_INVALID] = nv;
    sf[F_DIVIDE_BY_ZERO] = dz;
    lt = ua.mant < ub.mant;
    ge = r >= {1'b0, ub.mant};
    rem = 24'(ge ? r - {1'b0, ub.mant} : r);
    g = q[1];
    rb = q[0];
    st = |r;
    inc = g & (rb | st | q[2]);
    m_r = {1'b0, q[25:2]} + 25'(inc);
    e_r = e + 10'(m_r[24]);
    of = $signed(e_r) > 10'sd254;
    uf = $signed(e_r) < 10'sd1;
    rnd_bits = of ? {sign, 8'hFF, 23'd0} : uf ? {sign, 31'd0} :
               {sign, e_r[7:0], m_r[24] ? m_r[23:1] : m_r[22:0]};
    rf = '0;
    rf[F_OVERFLOW] = of;
    rf[F_UNDERFLOW] = uf;
    rf[F_INEXACT] = of | uf | g | rb | st;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_bits <= '0;
      except_flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a_bits;
          b_q <= b_bits;
          state <= NORM;
        end
        NORM: if (special) begin
          out_bits <= spec_bits;
          except_flags <= sf;
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          // pre-shift the smaller dividend so the quotient lands in [1,2)
          r <= lt ? {ua.mant, 1'b0} : {1'b0, ua.mant};
          e <= ua.exp - ub.exp + 10'(BIAS) - 10'(lt);
          q <= '0;
          cnt <= '0;
          state <= DIV;
        end
        DIV: begin
          r <= {rem, 1'b0};
          q <= {q[24:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) state <= ROUND;
        end
        ROUND: begin
          out_bits <= rnd_bits;
          except_flags <= rf;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vectors with hand-computed quotients, flags and latencies
module tb_fp_div_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a_bits = '0, b_bits = '0, out_bits;
  logic [4:0] except_flags;
  logic in_ready, out_valid;
  int total = 0, passed = 0;
  localparam logic [4:0] NV = 5'h10, DZ = 5'h08, OF = 5'h04, UF = 5'h02, NX = 5'h01;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .a_bits(a_bits), .b_bits(b_bits), .in_valid(in_valid),
    .in_ready(in_ready), .out_bits(out_bits), .except_flags(except_flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_bits = a;
    b_bits = b;
    in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [4:0] f, input int lat);
    int n = 0;
    start(tag, a, b);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " bits"}, out_bits, q);
    check({tag, " flags"}, 32'(except_flags), 32'(f));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " drained"}, 32'(out_valid), 0);
    check({tag, " idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_bits", out_bits, 0);
    check("reset flags", 32'(except_flags), 0);
    check("reset in_ready", 32'(in_ready), 0);
    @(negedge clk) rst = 1'b0;
    run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28); drain("6/2");
    run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX, 28); drain("1/3");
    run_op("2/3", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, NX, 28); drain("2/3");
    run_op("-6/2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 28); drain("-6/2");
    run_op("1/1", 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'h00, 28); drain("1/1");
    run_op("sub/sub", 32'h00400000, 32'h00200000, 32'h40000000, 5'h00, 28); drain("sub/sub");
    run_op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, DZ, 1); drain("1/0");
    run_op("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, DZ, 1); drain("-1/0");
    run_op("0/-0", 32'h00000000, 32'h80000000, 32'h7FC00000, NV, 1); drain("0/-0");
    run_op("-inf/1", 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h00, 1); drain("-inf/1");
    run_op("inf/-inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, NV, 1); drain("inf/-inf");
    run_op("nan/1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, NV, 1); drain("nan/1");
    run_op("-1/inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 5'h00, 1); drain("-1/inf");
    run_op("0/5", 32'h00000000, 32'h40A00000, 32'h00000000, 5'h00, 1); drain("0/5");
    run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, OF | NX, 28); drain("overflow");
    run_op("underflow", 32'h00800000, 32'h4B000000, 32'h00000000, UF | NX, 28); drain("underflow");
    run_op("stall", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall valid", 32'(out_valid), 1);
      check("stall bits", out_bits, 32'h40400000);
      check("stall flags", 32'(except_flags), 0);
      check("stall in_ready", 32'(in_ready), 0);
    end
    drain("stall");
    run_op("after stall", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX, 28); drain("after stall");
    start("abort", 32'h40C00000, 32'h40000000);
    repeat (11) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid", 32'(out_valid), 0);
    check("abort in_ready in rst", 32'(in_ready), 0);
    @(negedge clk) rst = 1'b0;
    #1 check("abort in_ready", 32'(in_ready), 1);
    bad = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid) bad++;
    end
    check("abort no result", 32'(bad), 0);
    run_op("post abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28); drain("post abort");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
